clock_alarm_core: RTL

- Parametrised time-of-day core: HH:MM:SS counter with selectable tick rate, bidirectional setting, alarm register with ringing timeout, and 12/24 h display conversion.
- Sits between the button debouncers and the seven-segment converters in the clock top level.
- Consumes single-cycle debounced pulses; emits binary display fields.
- Supersedes the fixed run/stop clock: adds decrement, alarm, 12 h mode and a field-blink mask.

---
 rtl/clock_alarm_core_pkg.sv | 32 +++
 rtl/mod_updown_counter.sv | 40 ++++
 rtl/clock_alarm_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clock_alarm_core_pkg.sv
// Shared encodings and limits for the time-of-day / alarm core.
// Also holds the 24 h -> 12 h hour mapping used by the display path.
package clock_alarm_core_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StSetTime  = 2'd1,
    StSetAlarm = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FldSec  = 2'd0,
    FldMin  = 2'd1,
    FldHour = 2'd2
  } field_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  // Midnight and noon both show as 12; the caller derives am/pm separately.
  function automatic logic [4:0] hour_12h(input logic [4:0] hour);
    if (hour == 5'd0) begin
      return 5'd12;
    end else if (hour > 5'd12) begin
      return hour - 5'd12;
    end else begin
      return hour;
    end
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with synchronous reset.
// The wrap output flags an increment from MODULUS-1 back to 0 in the current cycle.
module mod_updown_counter
  import clock_alarm_core_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  localparam int unsigned W = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MaxVal = W'(MODULUS - 1);

  logic [W-1:0] r_value;
  logic         w_up;
  logic         w_dn;

  // Simultaneous incr and decr cancel out.
  assign w_up = incr & ~decr;
  assign w_dn = decr & ~incr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (w_up) begin
      r_value <= (r_value == MaxVal) ? '0 : r_value + 1'b1;
    end else if (w_dn) begin
      r_value <= (r_value == '0) ? MaxVal : r_value - 1'b1;
    end
  end

  assign wrap  = w_up && (r_value == MaxVal);
  assign value = r_value;

endmodule

// File: rtl/clock_alarm_core.sv
// HH:MM:SS clock with run/set-time/set-alarm modes, ringing alarm with timeout,
// and 12/24 h display conversion.
module clock_alarm_core
  import clock_alarm_core_pkg::*;
#(
  parameter int unsigned FREQUENCY    = 50000000,
  parameter int unsigned RING_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_p,
  input  logic       next_p,
  input  logic       incr_p,
  input  logic       decr_p,
  input  logic       alarm_tog_p,
  input  logic       h12,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [4:0] disp_hour,
  output logic       disp_pm,
  output logic [2:0] edit_mask,
  output logic       alarm_en,
  output logic       ringing,
  output logic       tick
);

  localparam int unsigned CW = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;

  state_e        r_state;
  field_e        r_field;
  logic [CW-1:0] r_cyc;
  logic          r_alarm_en;
  logic          r_ringing;
  logic [5:0]    r_ring_cnt;

  logic [5:0] w_sec, w_min, w_amin, w_min_nxt;
  logic [4:0] w_hour, w_ahour, w_hour_nxt, w_dhour;
  logic       w_tick, w_edit_time, w_edit_alarm, w_match;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap, w_amin_wrap, w_ahour_wrap;
  logic       w_unused_wraps;

  assign w_edit_time  = (r_state == StSetTime);
  assign w_edit_alarm = (r_state == StSetAlarm);
  assign w_tick       = !w_edit_time && (r_cyc == CW'(FREQUENCY - 1));

  // Tick-driven carries only; manual edits never ripple into neighbours.
  mod_updown_counter #(.MODULUS(SEC_MAX + 1)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .incr (w_tick | (w_edit_time && r_field == FldSec && incr_p)),
    .decr (w_edit_time && r_field == FldSec && decr_p),
    .value(w_sec),
    .wrap (w_sec_wrap)
  );

  mod_updown_counter #(.MODULUS(MIN_MAX + 1)) u_min (
    .clk  (clk),
    .rst  (rst),
    .incr ((w_tick & w_sec_wrap) | (w_edit_time && r_field == FldMin && incr_p)),
    .decr (w_edit_time && r_field == FldMin && decr_p),
    .value(w_min),
    .wrap (w_min_wrap)
  );

  mod_updown_counter #(.MODULUS(HOUR_MAX + 1)) u_hour (
    .clk  (clk),
    .rst  (rst),
    .incr ((w_tick & w_min_wrap) | (w_edit_time && r_field == FldHour && incr_p)),
    .decr (w_edit_time && r_field == FldHour && decr_p),
    .value(w_hour),
    .wrap (w_hour_wrap)
  );

  mod_updown_counter #(.MODULUS(MIN_MAX + 1)) u_alarm_min (
    .clk  (clk),
    .rst  (rst),
    .incr (w_edit_alarm && r_field == FldMin && incr_p),
    .decr (w_edit_alarm && r_field == FldMin && decr_p),
    .value(w_amin),
    .wrap (w_amin_wrap)
  );

  mod_updown_counter #(.MODULUS(HOUR_MAX + 1)) u_alarm_hour (
    .clk  (clk),
    .rst  (rst),
    .incr (w_edit_alarm && r_field == FldHour && incr_p),
    .decr (w_edit_alarm && r_field == FldHour && decr_p),
    .value(w_ahour),
    .wrap (w_ahour_wrap)
  );

  assign w_unused_wraps = w_amin_wrap ^ w_ahour_wrap;

  // Post-tick time; only meaningful when w_tick is high (no time edits then).
  assign w_min_nxt  = w_min_wrap ? 6'd0 : (w_sec_wrap ? w_min + 6'd1 : w_min);
  assign w_hour_nxt = w_hour_wrap ? 5'd0 : (w_min_wrap ? w_hour + 5'd1 : w_hour);
  assign w_match    = w_sec_wrap && (w_min_nxt == w_amin) && (w_hour_nxt == w_ahour);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StRun;
      r_field    <= FldSec;
      r_cyc      <= '0;
      r_alarm_en <= 1'b0;
      r_ringing  <= 1'b0;
      r_ring_cnt <= '0;
    end else begin
      if (w_edit_time || w_tick) begin
        r_cyc <= '0;
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end

      if (mode_p) begin
        case (r_state)
          StRun: begin
            r_state <= StSetTime;
            r_field <= FldSec;
          end
          StSetTime: begin
            r_state <= StSetAlarm;
            r_field <= FldMin;
          end
          default: begin
            r_state <= StRun;
            r_field <= FldSec;
          end
        endcase
      end else if (next_p && w_edit_time) begin
        case (r_field)
          FldSec:  r_field <= FldMin;
          FldMin:  r_field <= FldHour;
          default: r_field <= FldSec;
        endcase
      end else if (next_p && w_edit_alarm) begin
        r_field <= (r_field == FldMin) ? FldHour : FldMin;
      end

      // A pulse that dismisses ringing is consumed and does not toggle alarm_en.
      if (r_ringing) begin
        if (alarm_tog_p || mode_p) begin
          r_ringing <= 1'b0;
        end else if (w_tick) begin
          if (r_ring_cnt == 6'(RING_SECONDS - 1)) begin
            r_ringing <= 1'b0;
          end else begin
            r_ring_cnt <= r_ring_cnt + 6'd1;
          end
        end
      end else begin
        if (alarm_tog_p && r_state == StRun) begin
          r_alarm_en <= ~r_alarm_en;
        end
        if (w_tick && r_alarm_en && w_match) begin
          r_ringing  <= 1'b1;
          r_ring_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    disp_sec = w_sec;
    disp_min = w_min;
    w_dhour  = w_hour;
    if (w_edit_alarm) begin
      disp_sec = '0;
      disp_min = w_amin;
      w_dhour  = w_ahour;
    end
    disp_hour = h12 ? hour_12h(w_dhour) : w_dhour;
    disp_pm   = h12 && (w_dhour >= 5'd12);

    edit_mask = 3'b000;
    if (r_state != StRun) begin
      case (r_field)
        FldSec:  edit_mask = 3'b001;
        FldMin:  edit_mask = 3'b010;
        default: edit_mask = 3'b100;
      endcase
    end
  end

  assign tick     = w_tick;
  assign alarm_en = r_alarm_en;
  assign ringing  = r_ringing;

endmodule
